// File: rtl/idu_pkg.sv
// Shared definitions for the IncDec-unit arbiter: op encodings, FSM states,
// default requester count and the pointer-width helper.
package idu_pkg;

    localparam int NREQ_DEF = 3;

    typedef enum logic [1:0] {
        OP_PASS     = 2'b00,
        OP_INC      = 2'b01,
        OP_DEC      = 2'b10,
        OP_PASS_ALT = 2'b11
    } idu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE
    } idu_state_e;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first asserted request at or after ptr, wrapping
// around to index 0.
module rr_pick
    import idu_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic            vld
);

    // The first pass covers ptr..NREQ-1. The second pass can only hit an index
    // below ptr, because nothing at or above ptr was requesting.
    always_comb begin
        gnt = '0;
        vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!vld && req[i] && (i >= int'(ptr))) begin
                gnt[i] = 1'b1;
                vld    = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!vld && req[i]) begin
                gnt[i] = 1'b1;
                vld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/idu_arbiter.sv
// Arbitrates PC/SP/HL requests for the shared 16-bit IncDec unit.
// Each operation takes two cycles: ISSUE (operand and op driven) then CAPTURE (result and ack).
module idu_arbiter
    import idu_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic                CLK,
    input  logic                nRESET,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   op,
    input  logic [16*NREQ-1:0]  val,
    output logic [NREQ-1:0]     ack,
    output logic [15:0]         res,
    output logic                busy,
    output logic                idu_inc,
    output logic                idu_dec,
    output logic [7:0]          idu_cbus,
    output logic [7:0]          idu_dbus,
    input  logic [7:0]          idu_adl_n,
    input  logic [7:0]          idu_adh_n,
    output logic [15:0]         addr_bus
);

    localparam int PW = ptr_w(NREQ);

    idu_state_e      state;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] ack_q;
    logic [PW-1:0]   ptr_q;
    logic [15:0]     opnd_q;

    logic [NREQ-1:0] pick_req;
    logic [NREQ-1:0] pick_gnt;
    logic            pick_vld;
    idu_op_e         pick_op;
    logic [15:0]     pick_val;
    logic [PW-1:0]   pick_nxt;

    // The requester being acked in CAPTURE still holds req and must not win again.
    assign pick_req = (state == ST_CAPTURE) ? (req & ~gnt_q) : req;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req  (pick_req),
        .ptr  (ptr_q),
        .gnt  (pick_gnt),
        .vld  (pick_vld)
    );

    always_comb begin
        pick_op  = OP_PASS;
        pick_val = '0;
        pick_nxt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                pick_op  = idu_op_e'(op[2*i +: 2]);
                pick_val = val[16*i +: 16];
                pick_nxt = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state   <= ST_IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            ptr_q   <= '0;
            opnd_q  <= '0;
            res     <= '0;
            busy    <= 1'b0;
            idu_inc <= 1'b0;
            idu_dec <= 1'b0;
        end else begin
            ack_q   <= '0;
            idu_inc <= 1'b0;
            idu_dec <= 1'b0;
            case (state)
                ST_ISSUE: begin
                    state <= ST_CAPTURE;
                    res   <= ~{idu_adh_n, idu_adl_n};
                    ack_q <= gnt_q & req;
                end
                default: begin
                    if (pick_vld) begin
                        state   <= ST_ISSUE;
                        busy    <= 1'b1;
                        gnt_q   <= pick_gnt;
                        ptr_q   <= pick_nxt;
                        opnd_q  <= pick_val;
                        idu_inc <= (pick_op == OP_INC);
                        idu_dec <= (pick_op == OP_DEC);
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Gating with nRESET keeps a reset that lands on a CAPTURE cycle from leaking an ack.
    assign ack      = ack_q & {NREQ{nRESET}};
    assign addr_bus = opnd_q;
    assign idu_cbus = opnd_q[7:0];
    assign idu_dbus = opnd_q[15:8];

endmodule

// File: tb/tb_idu_arbiter.sv
// Bench for idu_arbiter: a transaction-level reference model plus an external
// IncDec unit, driven by directed scenarios followed by random requester traffic.
module tb_idu_arbiter;

    localparam int NREQ = 3;

    logic              CLK = 1'b0;
    logic              nRESET;
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] op;
    logic [16*NREQ-1:0] val;
    logic [NREQ-1:0]   ack;
    logic [15:0]       res;
    logic              busy;
    logic              idu_inc;
    logic              idu_dec;
    logic [7:0]        idu_cbus;
    logic [7:0]        idu_dbus;
    logic [7:0]        idu_adl_n;
    logic [7:0]        idu_adh_n;
    logic [15:0]       addr_bus;

    always #5 CLK = ~CLK;

    // External IncDec unit; it returns its result with inverted polarity.
    logic [15:0] ext_sum;
    always_comb begin
        ext_sum = {idu_dbus, idu_cbus};
        if (idu_inc)      ext_sum = ext_sum + 16'd1;
        else if (idu_dec) ext_sum = ext_sum - 16'd1;
    end
    assign idu_adl_n = ~ext_sum[7:0];
    assign idu_adh_n = ~ext_sum[15:8];

    idu_arbiter #(.NREQ(NREQ)) dut (
        .CLK       (CLK),
        .nRESET    (nRESET),
        .req       (req),
        .op        (op),
        .val       (val),
        .ack       (ack),
        .res       (res),
        .busy      (busy),
        .idu_inc   (idu_inc),
        .idu_dec   (idu_dec),
        .idu_cbus  (idu_cbus),
        .idu_dbus  (idu_dbus),
        .idu_adl_n (idu_adl_n),
        .idu_adh_n (idu_adh_n),
        .addr_bus  (addr_bus)
    );

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] apply_op(input logic [1:0] o, input logic [15:0] v);
        case (o)
            2'b01:   return v + 16'd1;
            2'b10:   return v - 16'd1;
            default: return v;
        endcase
    endfunction

    function automatic int arb(input logic [NREQ-1:0] r, input int last, input int excl);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (r[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    function automatic logic [15:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Reference model: m_stage 0 = nothing in flight, 1 = op being issued,
    // 2 = op completing this cycle.
    int              m_cur   = -1;
    int              m_stage = 0;
    int              m_last  = NREQ - 1;
    logic [1:0]      m_op    = 2'b00;
    logic [15:0]     m_val   = 16'h0000;
    logic [NREQ-1:0] e_ack   = '0;
    logic [15:0]     e_res   = 16'h0000;
    logic [15:0]     e_addr  = 16'h0000;
    logic            e_busy  = 1'b0;
    logic            e_inc   = 1'b0;
    logic            e_dec   = 1'b0;

    always @(posedge CLK) begin
        int g;
        if (!nRESET) begin
            m_cur = -1; m_stage = 0; m_last = NREQ - 1;
            e_ack = '0; e_res = 16'h0000; e_addr = 16'h0000;
            e_busy = 1'b0; e_inc = 1'b0; e_dec = 1'b0;
        end else begin
            e_ack = '0;
            e_inc = 1'b0;
            e_dec = 1'b0;
            if (m_stage == 1) begin
                e_res = apply_op(m_op, m_val);
                if (req[m_cur]) e_ack[m_cur] = 1'b1;
                m_stage = 2;
            end else begin
                g = arb(req, m_last, (m_stage == 2) ? m_cur : -1);
                if (g >= 0) begin
                    m_cur   = g;
                    m_last  = g;
                    m_op    = op[2*g +: 2];
                    m_val   = val[16*g +: 16];
                    m_stage = 1;
                    e_addr  = m_val;
                    e_inc   = (m_op == 2'b01);
                    e_dec   = (m_op == 2'b10);
                    e_busy  = 1'b1;
                end else begin
                    m_stage = 0;
                    m_cur   = -1;
                    e_busy  = 1'b0;
                end
            end
        end
    end

    logic            chk_en = 1'b0;
    logic [NREQ-1:0] ack_q  = '0;

    always @(negedge CLK) begin
        ack_q = ack;
        if (chk_en) begin
            chk("ack",  ack,      e_ack & {NREQ{nRESET}});
            chk("res",  res,      e_res);
            chk("busy", busy,     e_busy);
            chk("addr", addr_bus, e_addr);
            chk("inc",  idu_inc,  e_inc);
            chk("dec",  idu_dec,  e_dec);
            chk("cbus", idu_cbus, e_addr[7:0]);
            chk("dbus", idu_dbus, e_addr[15:8]);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_single(input int idx, input logic [1:0] o, input logic [15:0] v,
                             input logic [15:0] exp, input string tag);
        int k;
        op[2*idx +: 2]   = o;
        val[16*idx +: 16] = v;
        req[idx]          = 1'b1;
        for (k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (k == 1) chk({tag, "_addr"}, addr_bus, v);
            if (ack[idx]) break;
        end
        chk({tag, "_lat"}, k, 2);
        chk({tag, "_res"}, res, exp);
        tick();
        req[idx] = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nk;
        int          ord[6];
        int          tm[6];
        int          k;
        logic [15:0] v1;
        bit          pend[NREQ];
        int          cool[NREQ];

        nRESET = 1'b0;
        req    = '0;
        op     = '0;
        val    = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            cool[i] = 0;
        end

        tick();
        chk_en = 1'b1;
        tick();
        @(negedge CLK);
        chk("rst_busy", busy, 0);
        chk("rst_res", res, 0);
        chk("rst_addr", addr_bus, 0);
        tick();

        // First request presented together with reset release.
        nRESET = 1'b1;
        do_single(0, 2'b01, 16'h00FF, 16'h0100, "inc00ff");
        do_single(0, 2'b10, 16'h0000, 16'hFFFF, "dec0000");
        do_single(1, 2'b01, 16'hFFFF, 16'h0000, "incffff");
        do_single(1, 2'b00, 16'h1234, 16'h1234, "pass1234");
        do_single(2, 2'b11, 16'h5555, 16'h5555, "op11");

        // All three held continuously.
        op  = {2'b01, 2'b10, 2'b00};
        val = {16'hA000, 16'h0B00, 16'h00C0};
        req = '1;
        nk  = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge CLK);
            if (c >= 1) chk("rr_busy", busy, 1);
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i] && nk < 6) begin
                    ord[nk] = i;
                    tm[nk]  = c;
                    nk++;
                end
            end
        end
        chk("rr_count", nk, 6);
        for (int j = 0; j < nk; j++) begin
            chk("rr_order", ord[j], j % 3);
            chk("rr_time", tm[j], 2 + 2 * j);
        end
        tick();
        req = '0;
        repeat (4) tick();

        // Granted requester withdraws during ISSUE.
        v1 = 16'h3FFF;
        op[3:2] = 2'b01;
        val[31:16] = v1;
        req = 3'b010;
        tick();
        req = 3'b100;
        op[5:4] = 2'b10;
        val[47:32] = 16'h8000;
        tick();
        @(negedge CLK);
        chk("drop_ack1", ack[1], 0);
        chk("drop_res", res, 16'h4000);
        for (k = 1; k < 8; k++) begin
            @(negedge CLK);
            if (ack[2]) break;
        end
        chk("drop_next_lat", k, 2);
        chk("drop_next_res", res, 16'h7FFF);
        tick();
        req = '0;
        repeat (3) tick();

        // Reset lands on the CAPTURE cycle.
        op[1:0] = 2'b01;
        val[15:0] = 16'h0042;
        req = 3'b001;
        tick();
        tick();
        nRESET = 1'b0;
        @(negedge CLK);
        chk("rstcap_ack", ack, 0);
        tick();
        @(negedge CLK);
        chk("rstcap_res", res, 0);
        chk("rstcap_busy", busy, 0);
        chk("rstcap_addr", addr_bus, 0);
        tick();
        nRESET = 1'b1;
        req = 3'b011;
        for (k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (ack != '0) break;
        end
        chk("rstcap_lat", k, 2);
        chk("rstcap_first", ack, 3'b001);
        tick();
        req = '0;
        repeat (6) tick();

        // Random requester traffic.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i]) begin
                    if (ack_q[i]) begin
                        pend[i] = 1'b0;
                        req[i]  = 1'b0;
                        if ($urandom_range(0, 3) == 0) begin
                            pend[i] = 1'b1;
                            req[i]  = 1'b1;
                            op[2*i +: 2]    = 2'($urandom_range(0, 3));
                            val[16*i +: 16] = rnd_val();
                        end
                    end else if ($urandom_range(0, 31) == 0) begin
                        pend[i] = 1'b0;
                        req[i]  = 1'b0;
                        cool[i] = 4;
                    end else if ($urandom_range(0, 7) == 0) begin
                        op[2*i +: 2]    = 2'($urandom_range(0, 3));
                        val[16*i +: 16] = rnd_val();
                    end
                end else if (cool[i] > 0) begin
                    cool[i]--;
                end else if ($urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    req[i]  = 1'b1;
                    op[2*i +: 2]    = 2'($urandom_range(0, 3));
                    val[16*i +: 16] = rnd_val();
                end
            end
            nRESET = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        nRESET = 1'b1;
        req = '0;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
